// File: rtl/host_frame_delimit_pkg.sv
// Shared state encoding and framing constants for the host receive frame delimiter.
package host_frame_delimit_pkg;

  typedef enum logic [1:0] {
    idle_s = 2'd0,
    pre_s  = 2'd1,
    data_s = 2'd2,
    drop_s = 2'd3
  } rx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         DEF_MAX_LEN   = 1522;
  localparam int         BYTE_CNT_W    = 11;

endpackage

// File: rtl/host_frame_delimit_frame_byte_delay.sv
// Fixed-depth byte shift hold with occupancy tracking; the oldest byte leaves
// on a push into a full hold, or as a tail on a flush.
module frame_byte_delay #(
  parameter int DEPTH = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic       i_flush,
  input  logic       i_discard,
  input  logic [7:0] iv_byte,
  output logic [7:0] ov_byte,
  output logic       o_valid,
  output logic       o_tail
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_C = OCC_W'(DEPTH);

  logic [OCC_W-1:0] r_occ;
  logic             w_full;

  assign w_full = (r_occ == FULL_C);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [7:0] r_byte;
      if (gi == 0) begin : g_head
        always_ff @(posedge i_clk) begin
          if (!i_rst_n)    r_byte <= 8'd0;
          else if (i_push) r_byte <= iv_byte;
        end
      end else begin : g_shift
        always_ff @(posedge i_clk) begin
          if (!i_rst_n)    r_byte <= 8'd0;
          else if (i_push) r_byte <= g_stage[gi-1].r_byte;
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                  r_occ <= '0;
    else if (i_flush || i_discard) r_occ <= '0;
    else if (i_push && !w_full)    r_occ <= r_occ + 1'b1;
  end

  assign ov_byte = g_stage[DEPTH-1].r_byte;
  assign o_valid = w_full & (i_push | i_flush);
  assign o_tail  = i_flush;

endmodule

// File: rtl/host_frame_delimit.sv
// GMII receive to 9-bit {head/tail, byte} stream with preamble strip, truncation and error cut.
// Build option: HOST_FRAME_DELIMIT_FCS_STRIP_EN deepens the hold to 5 so the FCS is never emitted.
module host_frame_delimit
  import host_frame_delimit_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_gmii_rx_dv,
  input  logic [7:0]       iv_gmii_rxd,
  input  logic             i_gmii_rx_er,
  output logic [8:0]       ov_data,
  output logic             o_data_wr,
  output logic [CNT_W-1:0] ov_frame_cnt,
  output logic [CNT_W-1:0] ov_err_cnt,
  output logic [CNT_W-1:0] ov_trunc_cnt
);

`ifdef HOST_FRAME_DELIMIT_FCS_STRIP_EN
  localparam int HOLD_DEPTH = 5;
`else
  localparam int HOLD_DEPTH = 1;
`endif

  localparam logic [BYTE_CNT_W-1:0] MAX_LEN_C = BYTE_CNT_W'(MAX_LEN);
  localparam logic [BYTE_CNT_W-1:0] CNT_SAT_C = '1;

  rx_state_t             r_state, w_state_next;
  logic                  r_wait_idle;
  logic                  r_emitted;
  logic [BYTE_CNT_W-1:0] r_byte_cnt, w_cnt_next, w_cnt_inc;
  logic [8:0]            r_data;
  logic                  r_data_wr;
  logic [CNT_W-1:0]      r_frame_cnt, r_err_cnt, r_trunc_cnt;

  logic       w_push, w_flush, w_discard;
  logic       w_frame_inc, w_err_inc, w_trunc_inc;
  logic [7:0] w_hold_byte;
  logic       w_hold_valid, w_hold_tail;

  frame_byte_delay #(.DEPTH(HOLD_DEPTH)) u_hold (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_push    (w_push),
    .i_flush   (w_flush),
    .i_discard (w_discard),
    .iv_byte   (iv_gmii_rxd),
    .ov_byte   (w_hold_byte),
    .o_valid   (w_hold_valid),
    .o_tail    (w_hold_tail)
  );

  assign w_cnt_inc = (r_byte_cnt == CNT_SAT_C) ? r_byte_cnt : r_byte_cnt + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    w_discard    = 1'b0;
    w_cnt_next   = r_byte_cnt;
    w_frame_inc  = 1'b0;
    w_err_inc    = 1'b0;
    w_trunc_inc  = 1'b0;
    case (r_state)
      idle_s: begin
        // After reset, the tail of an interrupted frame is ignored until the line goes idle
        if (i_gmii_rx_dv && !r_wait_idle) begin
          if (iv_gmii_rxd == PREAMBLE_BYTE) begin
            w_state_next = pre_s;
          end else begin
            w_state_next = drop_s;
            w_err_inc    = 1'b1;
          end
        end
      end
      pre_s: begin
        if (!i_gmii_rx_dv) begin
          w_state_next = idle_s;
        end else if (i_gmii_rx_er) begin
          w_state_next = drop_s;
          w_err_inc    = 1'b1;
        end else if (iv_gmii_rxd == PREAMBLE_BYTE) begin
          w_state_next = pre_s;
        end else if (iv_gmii_rxd == SFD_BYTE) begin
          w_state_next = data_s;
          w_cnt_next   = '0;
          w_discard    = 1'b1;
        end else begin
          w_state_next = drop_s;
          w_err_inc    = 1'b1;
        end
      end
      data_s: begin
        if (!i_gmii_rx_dv) begin
          w_state_next = idle_s;
          if (r_emitted) begin
            w_flush     = 1'b1;
            w_frame_inc = 1'b1;
          end else begin
            w_discard = 1'b1;
          end
        end else if (i_gmii_rx_er) begin
          w_state_next = drop_s;
          w_err_inc    = 1'b1;
          w_flush      = r_emitted;
          w_discard    = ~r_emitted;
        end else begin
          w_push     = 1'b1;
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == MAX_LEN_C) begin
            w_state_next = drop_s;
            w_trunc_inc  = 1'b1;
          end
        end
      end
      drop_s: begin
        // Only a truncated frame still has emitted bytes here; its tail leaves now
        w_flush = r_emitted;
        if (!i_gmii_rx_dv) w_state_next = idle_s;
      end
      default: w_state_next = idle_s;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= idle_s;
      r_wait_idle <= 1'b1;
      r_byte_cnt  <= '0;
      r_emitted   <= 1'b0;
      r_data      <= 9'd0;
      r_data_wr   <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
      r_trunc_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_wait_idle <= r_wait_idle & i_gmii_rx_dv;
      r_byte_cnt  <= w_cnt_next;
      if (w_flush || w_discard) r_emitted <= 1'b0;
      else if (w_hold_valid)    r_emitted <= 1'b1;
      r_data_wr <= w_hold_valid;
      if (w_hold_valid) r_data <= {w_hold_tail | ~r_emitted, w_hold_byte};
      if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_err_inc)   r_err_cnt   <= r_err_cnt + 1'b1;
      if (w_trunc_inc) r_trunc_cnt <= r_trunc_cnt + 1'b1;
    end
  end

  assign ov_data      = r_data;
  assign o_data_wr    = r_data_wr;
  assign ov_frame_cnt = r_frame_cnt;
  assign ov_err_cnt   = r_err_cnt;
  assign ov_trunc_cnt = r_trunc_cnt;

endmodule

// File: tb/tb_host_frame_delimit.sv
// Directed and randomized frames checked against a frame-level expected-output model.
`timescale 1ns/1ps
module tb_host_frame_delimit;

  localparam int MAX_LEN = 1522;
  localparam int CNT_W   = 32;
`ifdef HOST_FRAME_DELIMIT_FCS_STRIP_EN
  localparam int HOLD = 5;
`else
  localparam int HOLD = 1;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_dv = 1'b0;
  logic [7:0]       rxd   = 8'd0;
  logic             rx_er = 1'b0;
  logic [8:0]       ov_data;
  logic             o_data_wr;
  logic [CNT_W-1:0] frame_cnt, err_cnt, trunc_cnt;

  always #5 clk = ~clk;

  host_frame_delimit #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_gmii_rx_dv (rx_dv),
    .iv_gmii_rxd  (rxd),
    .i_gmii_rx_er (rx_er),
    .ov_data      (ov_data),
    .o_data_wr    (o_data_wr),
    .ov_frame_cnt (frame_cnt),
    .ov_err_cnt   (err_cnt),
    .ov_trunc_cnt (trunc_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int first_wr_cyc = -1;
  int first_sample_cyc = 0;
  int gap_viol = 0;
  bit in_frm = 1'b0;
  bit prev_tail = 1'b0;

  logic [8:0]       obs_q[$];
  logic [8:0]       exp_q[$];
  logic [CNT_W-1:0] exp_frame = '0, exp_err = '0, exp_trunc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect writes and watch frame structure: head, then tail, then at least one idle cycle
  always @(negedge clk) begin
    if (o_data_wr) begin
      obs_q.push_back(ov_data);
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (prev_tail) gap_viol++;
      prev_tail = 1'b0;
      if (ov_data[8]) begin
        if (in_frm) begin
          in_frm    = 1'b0;
          prev_tail = 1'b1;
        end else begin
          in_frm = 1'b1;
        end
      end
    end else begin
      prev_tail = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    rx_dv = dv;
    rxd   = d;
    rx_er = er;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  // Preamble, SFD, n payload bytes, optional rx_er on byte e (1-based); start<0 means random bytes
  task automatic send_good(input int p, input int n, input int e, input int start, input int ifg);
    logic [7:0] b[$];
    int m;
    bit trunc;
    for (int i = 0; i < n; i++) b.push_back(start < 0 ? 8'($urandom) : 8'(start + i));
    trunc = 1'b0;
    if (e != 0 && e <= MAX_LEN) m = e - 1;
    else if (n >= MAX_LEN) begin
      m = MAX_LEN;
      trunc = 1'b1;
    end else m = n;
    if (trunc)       exp_trunc++;
    else if (e != 0) exp_err++;
    else if (m > HOLD) exp_frame++;
    // The last HOLD accepted bytes never leave except the oldest one, which becomes the tail
    if (m > HOLD)
      for (int i = 0; i <= m - HOLD; i++) exp_q.push_back({(i == 0) || (i == m - HOLD), b[i]});
    for (int i = 0; i < p; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, b[i], 1'(i + 1 == e));
      if (i == 0) first_sample_cyc = cyc;
    end
    gap(ifg);
  endtask

  task automatic send_nopre(input int extra, input int ifg);
    logic [7:0] d;
    d = 8'($urandom);
    if (d == 8'h55) d = 8'h12;
    drive(1'b1, d, 1'b0);
    for (int i = 0; i < extra; i++) drive(1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
    exp_err++;
    gap(ifg);
  endtask

  task automatic send_badpre(input int p, input int ifg);
    logic [7:0] d;
    for (int i = 0; i < p; i++) drive(1'b1, 8'h55, 1'b0);
    if ($urandom_range(0, 1) == 0) drive(1'b1, 8'h55, 1'b1);
    else begin
      d = 8'($urandom);
      if (d == 8'h55 || d == 8'hD5) d = 8'hA0;
      drive(1'b1, d, 1'b0);
    end
    for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom), 1'b0);
    exp_err++;
    gap(ifg);
  endtask

  task automatic check_phase(input string tag);
    for (int i = 0; i < HOLD + 6; i++) drive(1'b0, 8'h00, 1'b0);
    chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), obs_q[i], exp_q[i]);
    chk({tag, "_frame_cnt"}, frame_cnt, exp_frame);
    chk({tag, "_err_cnt"}, err_cnt, exp_err);
    chk({tag, "_trunc_cnt"}, trunc_cnt, exp_trunc);
    chk({tag, "_gap"}, gap_viol, 0);
    chk({tag, "_open"}, in_frm, 1'b0);
    $display("phase %s: %0d writes, frames=%0d errs=%0d truncs=%0d", tag, obs_q.size(),
             frame_cnt, err_cnt, trunc_cnt);
    obs_q.delete();
    exp_q.delete();
    first_wr_cyc = -1;
  endtask

  initial begin
    int kind;
    int n;
    int e;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0);
    chk("rst_data", ov_data, 9'd0);
    chk("rst_wr", o_data_wr, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_trunc_cnt", trunc_cnt, 0);
    rst_n = 1'b1;
    gap(2);

    send_good(7, 64, 0, 1, 3);
    chk("t1_latency", first_wr_cyc - first_sample_cyc + 1, HOLD + 1);
    check_phase("t1_basic64");

    send_good(2, 1, 0, 8'hAA, 2);
    check_phase("t2_single");

    send_good(7, 64, 20, 1, 3);
    check_phase("t3_rxer20");

    send_good(7, 1600, 0, 1, 1);
    send_good(7, 64, 0, 1, 3);
    check_phase("t4_trunc");

    send_nopre(10, 2);
    send_good(7, 64, 0, -1, 3);
    check_phase("t5_nopre");

    send_good(7, 5, 0, 1, 2);
    send_good(7, 6, 0, 1, 2);
    send_good(1, 2, 0, 1, 2);
    check_phase("t6_short");

    // Reset in the middle of a frame: the remainder must be ignored without counting
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(i + 1), 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 8'h11, 1'b0);
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    in_frm    = 1'b0;
    prev_tail = 1'b0;
    exp_frame = '0;
    exp_err   = '0;
    exp_trunc = '0;
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom), 1'b0);
    gap(2);
    send_good(3, 30, 0, -1, 3);
    check_phase("t7_midreset");

    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) send_nopre($urandom_range(0, 10), $urandom_range(1, 4));
      else if (kind == 1) send_badpre($urandom_range(1, 8), $urandom_range(1, 4));
      else if (kind == 2) begin
        for (int i = 0; i < $urandom_range(1, 8); i++) drive(1'b1, 8'h55, 1'b0);
        gap($urandom_range(1, 4));
      end else begin
        if ($urandom_range(0, 15) == 0) n = $urandom_range(MAX_LEN - 3, MAX_LEN + 3);
        else n = $urandom_range(0, 90);
        e = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
        send_good($urandom_range(1, 8), n, e, -1, $urandom_range(1, 4));
      end
      if (f % 10 == 9) check_phase($sformatf("rand%0d", f / 10));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
